// File: rtl/slideshow_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slideshow_pkg
//  Purpose  : Shared types and helpers for the slideshow frame writer.
//             Optional macro SLIDESHOW_CHECKSUM_EN adds the CKSUM state.
//  Revision : 1.0 - initial release
// ============================================================================
package slideshow_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 480;

    // Writer sequencing states; CKSUM exists only when the checksum is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef SLIDESHOW_CHECKSUM_EN
        ST_CKSUM = 2'd2,
`endif
        ST_DONE  = 2'd3
    } writer_state_t;

    // SDRAM pixel word layout: unused top byte, then R, G, B
    function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/slideshow_frame_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : slideshow_frame_writer_if
//  Purpose  : Host byte stream and SDRAM write-port signals of the writer.
//             master = host/SDRAM side, slave = frame writer.
//  Revision : 1.0 - initial release
// ============================================================================
interface slideshow_frame_writer_if #(
    parameter int ADDR_W = 21
);
    logic [7:0]        iBYTE;
    logic              iBYTE_VALID;
    logic              oBYTE_READY;
    logic              iWR_FULL;
    logic              oWRITE_SDRAM_EN;
    logic [31:0]       oWRITE_DATA;
    logic [ADDR_W-1:0] oWRITE_ADDR;

    modport master (
        output iBYTE, iBYTE_VALID, iWR_FULL,
        input  oBYTE_READY, oWRITE_SDRAM_EN, oWRITE_DATA, oWRITE_ADDR
    );

    modport slave (
        input  iBYTE, iBYTE_VALID, iWR_FULL,
        output oBYTE_READY, oWRITE_SDRAM_EN, oWRITE_DATA, oWRITE_ADDR
    );
endinterface
`default_nettype wire

// File: rtl/slideshow_frame_writer_rgb_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_byte_assembler
//  Purpose  : Collects R,G,B bytes into a 24-bit pixel. The pixel is flagged
//             in the same cycle its B byte is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_byte_assembler (
    input  wire         iCLK,
    input  wire         iRST_n,
    input  wire         iClear,
    input  wire         iByteFire,
    input  wire  [7:0]  iByte,
    output logic        oPixelValid,
    output logic [23:0] oPixel
);
    logic [1:0] r_phase;
    logic [7:0] r_red;
    logic [7:0] r_green;

    // Byte phase counter (R -> G -> B) and holding registers for R and G
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_phase <= 2'd0;
            r_red   <= 8'h00;
            r_green <= 8'h00;
        end else if (iClear) begin
            r_phase <= 2'd0;
        end else if (iByteFire) begin
            case (r_phase)
                2'd0: begin
                    r_red   <= iByte;
                    r_phase <= 2'd1;
                end
                2'd1: begin
                    r_green <= iByte;
                    r_phase <= 2'd2;
                end
                default: r_phase <= 2'd0;
            endcase
        end
    end

    assign oPixelValid = iByteFire && (r_phase == 2'd2);
    assign oPixel      = {r_red, r_green, iByte};
endmodule
`default_nettype wire

// File: rtl/slideshow_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : slideshow_frame_writer
//  Purpose  : Packs the host slideshow byte stream into 32-bit pixels and
//             writes NUM_IMAGES frames linearly into SDRAM, flagging the LCD
//             path while loading. Optional macro SLIDESHOW_CHECKSUM_EN adds
//             a trailing mod-256 checksum byte and the oCKSUM_ERR flag.
//  Revision : 1.0 - initial release
// ============================================================================
module slideshow_frame_writer
    import slideshow_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int NUM_IMAGES = 4,
    parameter int ADDR_W     = 21
) (
    input  wire                      iCLK,
    input  wire                      iRST_n,
    input  wire                      iStart,
    slideshow_frame_writer_if.slave  bus,
    output logic                     oLoading,
    output logic [3:0]               oImageIdx,
    output logic                     oDone,
    output logic                     oCKSUM_ERR
);
    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [3:0]     IMG_LAST = 4'(NUM_IMAGES - 1);

    writer_state_t     r_state;
    logic              r_loading;
    logic              r_done;
    logic              r_wr_en;
    logic [31:0]       r_wr_data;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [3:0]        r_img;

    logic              w_start;
    logic              w_ready;
    logic              w_fire;
    logic              w_pix_fire;
    logic              w_pix_valid;
    logic [23:0]       w_pixel;
    logic              w_last_pixel;

    assign w_start = (r_state == ST_IDLE) && iStart;

`ifdef SLIDESHOW_CHECKSUM_EN
    assign w_ready = ((r_state == ST_LOAD) || (r_state == ST_CKSUM)) && !bus.iWR_FULL;
`else
    assign w_ready = (r_state == ST_LOAD) && !bus.iWR_FULL;
`endif
    assign w_fire     = bus.iBYTE_VALID && w_ready;
    // Only pixel bytes feed the assembler; the checksum byte never does
    assign w_pix_fire = w_fire && (r_state == ST_LOAD);

    // Counters describe the pixel being assembled, so this flags its final B byte
    assign w_last_pixel = (r_img == IMG_LAST) && (r_x == X_LAST) && (r_y == Y_LAST);

    rgb_byte_assembler u_asm (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iClear      (w_start),
        .iByteFire   (w_pix_fire),
        .iByte       (bus.iBYTE),
        .oPixelValid (w_pix_valid),
        .oPixel      (w_pixel)
    );

    // Running linear address and x/y/image position, advanced in each strobe cycle
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_img  <= 4'd0;
        end else if (w_start) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_img  <= 4'd0;
        end else if (r_wr_en) begin
            r_addr <= r_addr + 1'b1;
            if (r_x == X_LAST) begin
                r_x <= '0;
                if (r_y == Y_LAST) begin
                    r_y   <= '0;
                    r_img <= r_img + 4'd1;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

`ifdef SLIDESHOW_CHECKSUM_EN
    logic [7:0] r_cksum;
    logic       r_cksum_err;
`endif

    // Load sequencer with registered write strobe, loading and done outputs
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= ST_IDLE;
            r_loading   <= 1'b0;
            r_done      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= 32'h0;
            r_wr_addr   <= '0;
`ifdef SLIDESHOW_CHECKSUM_EN
            r_cksum     <= 8'h00;
            r_cksum_err <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_state   <= ST_LOAD;
                        r_loading <= 1'b1;
`ifdef SLIDESHOW_CHECKSUM_EN
                        r_cksum     <= 8'h00;
                        r_cksum_err <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
`ifdef SLIDESHOW_CHECKSUM_EN
                    if (w_pix_fire) r_cksum <= r_cksum + bus.iBYTE;
`endif
                    if (w_pix_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= pack_pixel(w_pixel[23:16], w_pixel[15:8], w_pixel[7:0]);
                        r_wr_addr <= r_addr;
                        if (w_last_pixel) begin
`ifdef SLIDESHOW_CHECKSUM_EN
                            r_state <= ST_CKSUM;
`else
                            r_state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef SLIDESHOW_CHECKSUM_EN
                ST_CKSUM: begin
                    if (w_fire) begin
                        r_cksum_err <= (r_cksum != bus.iBYTE);
                        r_state     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    r_done    <= 1'b1;
                    r_loading <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oBYTE_READY     = w_ready;
    assign bus.oWRITE_SDRAM_EN = r_wr_en;
    assign bus.oWRITE_DATA     = r_wr_data;
    assign bus.oWRITE_ADDR     = r_wr_addr;
    assign oLoading            = r_loading;
    assign oImageIdx           = r_img;
    assign oDone               = r_done;
`ifdef SLIDESHOW_CHECKSUM_EN
    assign oCKSUM_ERR          = r_cksum_err;
`else
    assign oCKSUM_ERR          = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_slideshow_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slideshow_frame_writer
//  Purpose  : Randomized self-checking bench for slideshow_frame_writer with
//             a pixel-list reference model. Honours SLIDESHOW_CHECKSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slideshow_frame_writer;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NI   = 2;
    localparam int AW   = 5;
    localparam int NPIX = H * V * NI;
    localparam int NB   = 3 * NPIX;

    typedef struct packed {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic [3:0]    idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       loading;
    logic [3:0] img_idx;
    logic       done;
    logic       cksum_err;

    slideshow_frame_writer_if #(.ADDR_W(AW)) bus ();

    slideshow_frame_writer #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .NUM_IMAGES (NI),
        .ADDR_W     (AW)
    ) dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iStart     (start),
        .bus        (bus),
        .oLoading   (loading),
        .oImageIdx  (img_idx),
        .oDone      (done),
        .oCKSUM_ERR (cksum_err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_strobe = -1;
    int   done_cnt = 0;
    logic prev_loading = 1'b0;
    logic prev_done = 1'b0;
    exp_t exp_q[$];
    logic [7:0] stream [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: pixel k is bytes 3k..3k+2 at address k of image k/(H*V)
    task automatic build_expected(input int npix);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < npix; k++) begin
            e.data = {8'h00, stream[3*k], stream[3*k+1], stream[3*k+2]};
            e.addr = AW'(k);
            e.idx  = 4'(k / (H * V));
            exp_q.push_back(e);
        end
    endtask

    task automatic gen_stream(input bit fixed_head);
        for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
        if (fixed_head) begin
            stream[0] = 8'h11;
            stream[1] = 8'h22;
            stream[2] = 8'h33;
        end
    endtask

    // Monitor: strobes against the model, spacing and done/loading timing
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_loading = 1'b0;
            prev_done    = 1'b0;
        end else begin
            if (bus.oWRITE_SDRAM_EN) begin
                if (last_strobe >= 0) chk("strobe_spacing", 32'(cyc - last_strobe >= 3), 1);
                last_strobe = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", bus.oWRITE_DATA, e.data);
                    chk("wr_addr", 32'(bus.oWRITE_ADDR), 32'(e.addr));
                    chk("image_idx", 32'(img_idx), 32'(e.idx));
                end
            end
            if (prev_done) chk("done_one_cycle", 32'(done), 0);
            if (done) begin
                done_cnt++;
                chk("loading_falls_with_done", {30'd0, prev_loading, loading}, 32'b10);
`ifndef SLIDESHOW_CHECKSUM_EN
                chk("done_after_last_strobe", 32'(cyc - last_strobe), 1);
`endif
            end
            prev_loading = loading;
            prev_done    = done;
        end
    end

    // Present one byte from a negedge and hold it until the block takes it
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   waits;
        waits = 0;
        bus.iBYTE       = b;
        bus.iBYTE_VALID = 1'b1;
        forever begin
            #1;
            acc = bus.oBYTE_READY;
            @(negedge clk);
            if (acc) break;
            waits++;
            if (waits > 50) begin
                chk("byte_accept_timeout", 1, 0);
                break;
            end
        end
        bus.iBYTE_VALID = 1'b0;
    endtask

    task automatic do_start(input bit offer_byte);
        start = 1'b1;
        if (offer_byte) begin
            bus.iBYTE       = 8'hAA;
            bus.iBYTE_VALID = 1'b1;
        end
        #1;
        chk("idle_not_ready", 32'(bus.oBYTE_READY), 0);
        @(negedge clk);
        start           = 1'b0;
        bus.iBYTE_VALID = 1'b0;
        chk("loading_after_start", 32'(loading), 1);
`ifdef SLIDESHOW_CHECKSUM_EN
        chk("cksum_err_cleared", 32'(cksum_err), 0);
`endif
    endtask

    task automatic run_bytes(input int n, input int stall_at, input int spur_at);
        for (int i = 0; i < n; i++) begin
            if (i == spur_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("spurious_start_loading", 32'(loading), 1);
            end
            if (i == stall_at) begin
                bus.iWR_FULL    = 1'b1;
                bus.iBYTE       = stream[i];
                bus.iBYTE_VALID = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    chk("stall_ready_low", 32'(bus.oBYTE_READY), 0);
                    @(negedge clk);
                end
                bus.iWR_FULL = 1'b0;
            end
            send_byte(stream[i]);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic full_load(input int stall_at, input int spur_at, input bit offer_byte,
                             input bit bad_ck, input bit fixed_head);
        int d0;
        logic [7:0] sum;
        gen_stream(fixed_head);
        build_expected(NPIX);
        d0 = done_cnt;
        do_start(offer_byte);
        run_bytes(NB, stall_at, spur_at);
`ifdef SLIDESHOW_CHECKSUM_EN
        sum = 8'h00;
        for (int i = 0; i < NB; i++) sum = sum + stream[i];
        send_byte(bad_ck ? (sum ^ 8'h5A) : sum);
`else
        sum = 8'h00;
`endif
        for (int w = 0; w < 30 && done_cnt == d0; w++) @(negedge clk);
        chk("done_seen", 32'(done_cnt - d0), 1);
        chk("strobes_remaining", 32'(exp_q.size()), 0);
`ifdef SLIDESHOW_CHECKSUM_EN
        chk("cksum_err", 32'(cksum_err), 32'(bad_ck));
        repeat (4) @(negedge clk);
        chk("cksum_err_held", 32'(cksum_err), 32'(bad_ck));
`else
        chk("cksum_err_tied", 32'(cksum_err), 0);
`endif
    endtask

    initial begin
        clk             = 1'b0;
        rst_n           = 1'b0;
        start           = 1'b0;
        bus.iBYTE       = 8'h00;
        bus.iBYTE_VALID = 1'b0;
        bus.iWR_FULL    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_loading", 32'(loading), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_en", 32'(bus.oWRITE_SDRAM_EN), 0);
        chk("rst_wr_data", bus.oWRITE_DATA, 0);
        chk("rst_wr_addr", 32'(bus.oWRITE_ADDR), 0);
        chk("rst_img_idx", 32'(img_idx), 0);
        chk("rst_cksum_err", 32'(cksum_err), 0);
        chk("rst_ready", 32'(bus.oBYTE_READY), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean load with known first pixel
        full_load(-1, -1, 1'b0, 1'b0, 1'b1);
        // Write FIFO full for 5 cycles mid-stream
        full_load(10, -1, 1'b0, 1'b0, 1'b0);
        // Byte offered with iStart in IDLE, plus iStart pulsed during LOAD
        full_load(-1, 7, 1'b1, 1'b0, 1'b0);

        // Reset after 20 bytes, then a complete new load
        gen_stream(1'b0);
        build_expected(NPIX);
        do_start(1'b0);
        run_bytes(20, -1, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_loading", 32'(loading), 0);
        chk("midrst_wr_en", 32'(bus.oWRITE_SDRAM_EN), 0);
        chk("midrst_ready", 32'(bus.oBYTE_READY), 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_strobe", 32'(bus.oWRITE_SDRAM_EN), 0);
        exp_q.delete();
        last_strobe = -1;
        rst_n = 1'b1;
        @(negedge clk);
        full_load(-1, -1, 1'b0, 1'b0, 1'b0);

`ifdef SLIDESHOW_CHECKSUM_EN
        // Wrong checksum byte, then a good load that must clear the flag
        full_load(-1, -1, 1'b0, 1'b1, 1'b0);
        full_load(-1, -1, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/slideshow_frame_writer.md
Name: slideshow_frame_writer

Overview:
- Writer-side counterpart of the LCD display path.
- Accepts the slideshow byte stream from the host interface (PIC32 link) as R,G,B triplets and packs each triplet into a 32-bit pixel word.
- Writes the pixel words with linear addresses into the SDRAM write port, for NUM_IMAGES consecutive frames.
- Drives the loading flag that the LCD controller consumes, so the display knows when loading starts and ends.

Parameters:
- H_ACTIVE, 800: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- NUM_IMAGES, 4: frames per slideshow load; range 1..16.
- ADDR_W, 21: SDRAM pixel address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE*NUM_IMAGES.

Ports:
- iCLK  in  1  system clock.
- iRST_n  in  1  asynchronous active-low reset.
- iStart  in  1  one-cycle pulse that begins a slideshow load.
- iBYTE  in  8  host data byte.
- iBYTE_VALID  in  1  iBYTE is valid.
- oBYTE_READY  out  1  block accepts iBYTE this cycle.
- iWR_FULL  in  1  SDRAM write FIFO almost-full; at least 1 free slot remains while asserted.
- oWRITE_SDRAM_EN  out  1  one-cycle write strobe.
- oWRITE_DATA  out  32  pixel word {8'h00,R,G,B}.
- oWRITE_ADDR  out  ADDR_W  linear pixel address.
- oLoading  out  1  load in progress; feeds the LCD controller's loading input.
- oImageIdx  out  4  index of the image currently being written.
- oDone  out  1  one-cycle pulse when the load completes.
- oCKSUM_ERR  out  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, iCLK; reset iRST_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; all counters 0; byte phase 0.
- FSM states: IDLE, LOAD, CKSUM (present only with the macro), DONE.
- IDLE:
  - oBYTE_READY=0.
  - iStart=1 -> LOAD next cycle; oLoading=1 from that cycle; address, oImageIdx and checksum cleared.
- Handshake: a byte transfers when iBYTE_VALID && oBYTE_READY. In LOAD, oBYTE_READY = !iWR_FULL (combinational). A byte offered while iWR_FULL=1 is held by the host, not dropped.
- Byte phase: 0=R, 1=G, 2=B. Wraps 2->0 on each accepted B byte.
- Write timing:
  - B accepted at cycle N -> at cycle N+1: oWRITE_SDRAM_EN=1, oWRITE_DATA={8'h00,R,G,B}, oWRITE_ADDR = current pixel address.
  - The address increments after each write.
  - Strobes are never back-to-back closer than 3 cycles.
- Pixel bookkeeping:
  - x counts 0..H_ACTIVE-1; y counts 0..V_ACTIVE-1.
  - On the last pixel of a frame, x and y wrap to 0 and oImageIdx increments.
  - oWRITE_ADDR = oImageIdx*H_ACTIVE*V_ACTIVE + y*H_ACTIVE + x, held in a running counter (no multipliers).
- Completion:
  - Last B byte of image NUM_IMAGES-1 -> DONE (or CKSUM with the macro).
  - In DONE, oDone=1 for exactly one cycle, in the cycle after the final write strobe; oLoading falls in that same cycle. Then -> IDLE.
- iStart asserted in LOAD, CKSUM or DONE: ignored.
- iStart in the same cycle as iBYTE_VALID in IDLE: the byte is not accepted (ready=0).
- iWR_FULL rising while a write strobe is pending: the strobe still issues (the headroom guarantee covers it).
- Reset mid-load: immediate return to IDLE; oLoading=0; no pending strobe survives.

Optional Feature:
- Macro: SLIDESHOW_CHECKSUM_EN.
- Defined:
  - The block keeps a running 8-bit modulo-256 sum of every accepted pixel byte.
  - After the last B byte, state CKSUM asserts oBYTE_READY (gated by !iWR_FULL) and accepts exactly one checksum byte.
  - oCKSUM_ERR is registered as (sum != byte) and held until the next iStart.
  - Then -> DONE.
- Undefined: no CKSUM state; oCKSUM_ERR tied to 0.

Decomposition:
- Package slideshow_pkg:
  - H_ACTIVE/V_ACTIVE defaults.
  - writer_state_t enum.
  - Function pack_pixel(r,g,b) returning the 32-bit word.
- Sub-module rgb_byte_assembler: byte phase counter plus R/G holding registers; emits a pixel_valid pulse and a 24-bit pixel.

Test Plan (sim params H_ACTIVE=4, V_ACTIVE=2, NUM_IMAGES=2, ADDR_W=5):
- Reset, then iStart, then 48 bytes streamed with no stall -> 16 strobes at addresses 0..15; first word 32'h00_112233 for bytes 11,22,33; oImageIdx 0->1 after 8 strobes; oDone pulses 1 cycle after strobe 15; oLoading falls in the same cycle.
- iWR_FULL held 1 for 5 cycles mid-stream -> oBYTE_READY=0 for those cycles; no byte lost; addresses contiguous; data matches the stream.
- iStart pulsed during LOAD, plus a byte offered in IDLE the same cycle as iStart -> neither affects sequencing; the first strobe still carries bytes 1..3 after LOAD entry.
- iRST_n asserted after 20 bytes, released, then a full new load -> oLoading=0 during reset; the new load starts at address 0 with byte phase 0.
- SLIDESHOW_CHECKSUM_EN defined, 48 bytes plus a correct sum byte -> oCKSUM_ERR=0; repeat with a wrong sum byte -> oCKSUM_ERR=1 held until the next iStart; oDone pulses in both cases.
